// File: rtl/dq_burst_serdes.sv
// dq_burst_serdes: moves one LANES x BL burst over the DQ pins, one beat per mem_clk.
// Writes shift a loaded burst out beat 0 first with dq_oe asserted. Reads wait RL
// cycles after the command, then shift dq_i into an assembly register and publish
// the whole burst to rdata at once with a one-cycle rd_valid pulse.
// Optional feature macro: DQ_BURST_CHOP_EN adds cmd_bc (burst chop to BL/2 beats).
// BL must be >= 2 and even, and RL must be >= 1.
module dq_burst_serdes #(
    parameter int LANES = 16,
    parameter int BL    = 8,
    parameter int RL    = 4,
    parameter int DW    = LANES * BL
) (
    input  logic             mem_clk,
    input  logic             rst,
    // Command handshake: a command is accepted on a rising edge where cmd_valid and
    // cmd_ready are both high. cmd_ready is high only when idle. cmd_rw, wdata (and
    // cmd_bc) are sampled only on that edge. A request made while busy is not stored;
    // the requester keeps cmd_valid high until it is accepted.
    input  logic             cmd_valid,
    input  logic             cmd_rw,
`ifdef DQ_BURST_CHOP_EN
    input  logic             cmd_bc,
`endif
    output logic             cmd_ready,
    input  logic [DW-1:0]    wdata,
    output logic [LANES-1:0] dq_o,
    output logic             dq_oe,
    input  logic [LANES-1:0] dq_i,
    output logic [DW-1:0]    rdata,
    output logic             rd_valid,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int BCW = (BL > 1) ? $clog2(BL) : 1;
    localparam int WCW = $clog2(RL + 1);

    // Last beat index for a full burst and for a chopped (half) burst.
    localparam logic [BCW-1:0] FULL_LAST = BCW'(BL - 1);
    localparam logic [BCW-1:0] HALF_LAST = BCW'(BL / 2 - 1);
    // RD_WAIT lasts RL-1 cycles; the wait counter leaves it at this value.
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((RL >= 2) ? RL - 2 : 0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_WAIT  = 2'd2,
        RD_BURST = 2'd3
    } state_t;

    state_t           state_q;
    logic [BCW-1:0]   beat_q;
    logic [WCW-1:0]   wait_q;
    logic [DW-1:0]    sreg_q;
    logic             chop_q;
    logic [LANES-1:0] dq_o_q;
    logic             dq_oe_q;
    logic [DW-1:0]    rdata_q;
    logic             rd_valid_q;

    logic             cmd_bc_w;
    logic [BCW-1:0]   beat_last;
    logic [DW-1:0]    asm_d;
    logic [DW-1:0]    rdata_d;

`ifdef DQ_BURST_CHOP_EN
    assign cmd_bc_w = cmd_bc;
`else
    assign cmd_bc_w = 1'b0;
`endif

    assign beat_last = chop_q ? HALF_LAST : FULL_LAST;

    // Incoming beat enters at the top, so after the last beat beat 0 sits at the bottom.
    assign asm_d = {dq_i, sreg_q[DW-1:LANES]};

    // Burst published to rdata; a chopped burst occupies the top half of asm_d and the
    // upper half of rdata is zero.
    always_comb begin
        rdata_d = asm_d;
        if (chop_q) begin
            rdata_d = {{(DW / 2){1'b0}}, asm_d[DW-1:DW/2]};
        end
    end

    // Burst sequencer: command accept, write shift-out, read wait and read capture.
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            wait_q     <= '0;
            sreg_q     <= '0;
            chop_q     <= 1'b0;
            dq_o_q     <= '0;
            dq_oe_q    <= 1'b0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    beat_q <= '0;
                    wait_q <= '0;
                    if (cmd_valid) begin
                        chop_q <= cmd_bc_w;
                        if (cmd_rw) begin
                            state_q <= WR_BURST;
                            dq_o_q  <= wdata[LANES-1:0];
                            dq_oe_q <= 1'b1;
                            sreg_q  <= wdata >> LANES;
                        end else if (RL == 1) begin
                            state_q <= RD_BURST;
                        end else begin
                            state_q <= RD_WAIT;
                        end
                    end
                end
                WR_BURST: begin
                    if (beat_q == beat_last) begin
                        state_q <= IDLE;
                        dq_o_q  <= '0;
                        dq_oe_q <= 1'b0;
                        beat_q  <= '0;
                    end else begin
                        dq_o_q <= sreg_q[LANES-1:0];
                        sreg_q <= sreg_q >> LANES;
                        beat_q <= beat_q + BCW'(1);
                    end
                end
                RD_WAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        state_q <= RD_BURST;
                        wait_q  <= '0;
                    end else begin
                        wait_q <= wait_q + WCW'(1);
                    end
                end
                RD_BURST: begin
                    sreg_q <= asm_d;
                    if (beat_q == beat_last) begin
                        state_q    <= IDLE;
                        rdata_q    <= rdata_d;
                        rd_valid_q <= 1'b1;
                        beat_q     <= '0;
                    end else begin
                        beat_q <= beat_q + BCW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = ~cmd_ready;
    assign dq_o      = dq_o_q;
    assign dq_oe     = dq_oe_q;
    assign rdata     = rdata_q;
    assign rd_valid  = rd_valid_q;
    assign dbg_state = state_q;

endmodule
